hilo_muldiv_ctrl: RTL
=====================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO register pair.
//  Sits beside EX. Accepts one op from ID/EX, iterates a shift-add multiplier or a
//  restoring divider, then writes HI/LO. It also serialises MTHI/MTLO/MFHI/MFLO
//  against an in-flight op and raises a pipeline stall while they conflict.
// PARAMETERS
//  XLEN   32           operand width; HI and LO are XLEN each
//  CNT_W  $clog2(XLEN) width of the iteration counter
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous reset, active-high
//  start      in   1     op request, valid for one accepted cycle
//  op         in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a      in   XLEN  rs: multiplicand / dividend
//  src_b      in   XLEN  rt: multiplier / divisor
//  flush      in   1     cancel the in-flight op (branch/exception squash)
//  mf_req     in   1     EX holds MFHI or MFLO
//  mt_hi_wen  in   1     MTHI write request
//  mt_lo_wen  in   1     MTLO write request
//  mt_data    in   XLEN  MTHI/MTLO data
//  busy       out  1     FSM is not in IDLE
//  stall      out  1     freeze IF..EX this cycle
//  done       out  1     one-cycle pulse, the cycle HI/LO become valid
//  hi         out  XLEN  HI register
//  lo         out  XLEN  LO register
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, stall=0, done=0; hi=0, lo=0; counter=0.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start&!flush in cycle N latches the operands.
//         Signed ops take |a| and |b| and latch neg_q=sa^sb, neg_r=sa.
//   CALC: cycles N+1..N+32. Counter counts XLEN-1 down to 0, one bit per cycle.
//         MUL: if the multiplier LSB is 1, add the multiplicand into the 2*XLEN accumulator; then shift.
//         DIV: shift the remainder, trial-subtract, set the quotient bit.
//   FIX: cycle N+33. Apply the sign fixes, then write {HI,LO} at the closing edge.
//         MUL: {hi,lo} = neg_q ? -prod : prod.
//         DIV: lo = neg_q ? -q : q; hi = neg_r ? -r : r.
//  Latency: the result is visible in cycle N+34. done=1 in N+34. busy=1 in N+1..N+33.
//  Divide by zero (DIV or DIVU): hi=src_a, lo=XLEN'hFFFF_FFFF. No exception.
//  DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. The wrap is intended.
//  Stall rule: stall = busy & (start | mf_req | mt_hi_wen | mt_lo_wen).
//   A start is ignored while busy; upstream holds it under stall.
//  MT writes are taken only when !busy. They take effect at the next edge.
//   MT and start in the same IDLE cycle: the MT write lands first, and the op result later overwrites it.
//  flush: from any state, return to IDLE next cycle. hi/lo are unchanged, no done.
//   flush wins over start in the same cycle.
//  Reset mid-op: everything returns to its reset values immediately (asynchronous).
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   - In CALC for MULT/MULTU, move to FIX as soon as the remaining multiplier bits are all 0.
//   - Latency is (index of the highest set bit of |b|)+1 CALC cycles, minimum 1, plus FIX.
//   - DIV is unaffected.
//  MULDIV_EARLY_OUT_EN undefined: always XLEN CALC cycles.
// STRUCTURE
//  muldiv_pkg: op encodings (OP_MULT..OP_DIVU), state enum (S_IDLE,S_CALC,S_FIX), XLEN default.
//  Sub-module muldiv_iter_core: the accumulator/remainder datapath with a one-step-per-cycle interface.
//  The FSM, HI/LO registers and stall logic stay in this module.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF at N -> hi=0xFFFFFFFE, lo=0x00000001, done at N+34.
//  2. MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3. DIVU 100/0 -> hi=0x00000064, lo=0xFFFFFFFF. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4. Start MULTU 5*6, flush at N+10 -> busy=0 at N+11, hi/lo unchanged, no done.
//  5. MTHI 0xA5A5A5A5 asserted at N+5 of a MULTU -> stall=1 until N+33; after done, MTHI applies and hi=0xA5A5A5A5.
//  6. With MULDIV_EARLY_OUT_EN: MULTU 5*3 -> 2 CALC cycles, lo=15 visible at N+4.
//     Without the macro, lo=15 is visible at N+34.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// sequencer states and the default operand width.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath for unsigned magnitudes: one shift-add multiply step or
// one restoring-divide step per cycle while 'step' is high.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem,
  output logic              mul_last
);

  logic              div_mode;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   dvsr;
  logic [XLEN-1:0]   quot_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;

  // Remainder stays below the divisor, so one extra bit holds the trial value;
  // the top bit of the difference is the borrow that decides the quotient bit.
  assign trial = {rem_r, quot_r[XLEN-1]};
  assign diff  = trial - {1'b0, dvsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_mode <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      dvsr     <= '0;
      quot_r   <= '0;
      rem_r    <= '0;
    end else if (load) begin
      div_mode <= is_div;
      acc      <= '0;
      mcand    <= {{XLEN{1'b0}}, a};
      mplier   <= b;
      dvsr     <= b;
      quot_r   <= a;
      rem_r    <= '0;
    end else if (step) begin
      if (div_mode) begin
        rem_r  <= diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
        quot_r <= {quot_r[XLEN-2:0], ~diff[XLEN]};
      end else begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  assign prod     = acc;
  assign quot     = quot_r;
  assign rem      = rem_r;
  assign mul_last = (mplier[XLEN-1:1] == '0);

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MT/MF serialisation stall.
// Define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic            mf_req,
  input  logic            mt_hi_wen,
  input  logic            mt_lo_wen,
  input  logic [XLEN-1:0] mt_data,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              div_r, neg_q, neg_r, div_zero;
  logic              is_div, is_signed, sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              load, step, calc_done, mul_last;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, rem, q_fix, r_fix;

  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = is_signed & src_a[XLEN-1];
  assign sb        = is_signed & src_b[XLEN-1];
  assign abs_a     = sa ? -src_a : src_a;
  assign abs_b     = sb ? -src_b : src_b;

  assign busy      = (state != S_IDLE);
  assign stall     = busy & (start | mf_req | mt_hi_wen | mt_lo_wen);
  assign calc_done = (cnt == '0) || (EARLY_OUT && !div_r && mul_last);

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !flush) begin
          load       = 1'b1;
          next_state = S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (flush) begin
          next_state = S_IDLE;
        end else if (calc_done) begin
          next_state = S_FIX;
        end
      end
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_r    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state == S_FIX) && !flush;
      if (load) begin
        cnt      <= CNT_W'(XLEN - 1);
        div_r    <= is_div;
        neg_q    <= sa ^ sb;
        neg_r    <= sa;
        div_zero <= is_div && (src_b == '0);
      end else if (step) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .is_div   (is_div),
    .a        (abs_a),
    .b        (abs_b),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .mul_last (mul_last)
  );

  // A zero divisor leaves the remainder equal to |a|, so only the quotient needs forcing.
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = div_zero ? '1 : (neg_q ? -quot : quot);
  assign r_fix    = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX && !flush) begin
      if (div_r) begin
        hi <= r_fix;
        lo <= q_fix;
      end else begin
        {hi, lo} <= prod_fix;
      end
    end else if (state == S_IDLE) begin
      if (mt_hi_wen) hi <= mt_data;
      if (mt_lo_wen) lo <= mt_data;
    end
  end

endmodule
